// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO package: depth-to-address helper and flag reset constants
// Purpose: common types and constants for the sync and async FIFO tops.
// Ports: none (package).
package fifo_pkg;

    // Smallest address width whose power of two covers the requested depth.
    function automatic int addr_size_for_depth(input int depth);
        int n;
        n = 0;
        while ((1 << n) < depth) begin
            n = n + 1;
        end
        return n;
    endfunction

    typedef struct packed {
        logic w_full;
        logic r_empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // Empty FIFO: almost_empty is always true at level 0 since the threshold is >= 0.
    localparam fifo_flags_t FIFO_FLAGS_RST = '{
        w_full:       1'b0,
        r_empty:      1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer interface of the single-clock FIFO
// Purpose: bundles write, read, error-clear and status signals.
// Ports: master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    w_en;
    logic [MEMORY_WIDTH-1:0] wdata;
    logic                    r_en;
    logic                    err_clr;
    logic [MEMORY_WIDTH-1:0] rdata;
    logic                    w_full;
    logic                    r_empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic [ADDRESS_SIZE:0]   level;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output w_en, wdata, r_en, err_clr,
        input  rdata, w_full, r_empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  w_en, wdata, r_en, err_clr,
        output rdata, w_full, r_empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_mem.sv
// rtl/fifo_sync_mem.sv - 1W/1R RAM with registered or asynchronous read
// Purpose: storage for fifo_sync_param; contents are never reset.
// Ports: clk, rst (clears the read register), w_en_i/w_addr_i/wdata_i write port,
//        r_en_i/r_addr_i read port, rdata_o read data.
module fifo_sync_mem #(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter bit FWFT         = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en_i,
    input  logic [ADDRESS_SIZE-1:0] w_addr_i,
    input  logic [MEMORY_WIDTH-1:0] wdata_i,
    input  logic                    r_en_i,
    input  logic [ADDRESS_SIZE-1:0] r_addr_i,
    output logic [MEMORY_WIDTH-1:0] rdata_o
);
    logic [MEMORY_WIDTH-1:0] mem_q [2**ADDRESS_SIZE];

    always_ff @(posedge clk) begin
        if (w_en_i) begin
            mem_q[w_addr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT) begin : g_async_read
            // Head word is presented directly; read enable and reset have no role here.
            logic unused_fwft;
            assign unused_fwft = r_en_i ^ rst;
            assign rdata_o     = mem_q[r_addr_i];
        end else begin : g_reg_read
            logic [MEMORY_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (r_en_i) begin
                    rdata_q <= mem_q[r_addr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with level, thresholds and sticky errors
// Purpose: same-domain buffer between a producer and a consumer; registered or FWFT read.
// Ports: clk, rst (async, active-high), bus (slave modport: w_en, wdata, r_en, err_clr in;
//        rdata, w_full, r_empty, almost_full, almost_empty, level, overflow, underflow out).
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int MEMORY_WIDTH    = 8,
    parameter int ADDRESS_SIZE    = 4,
    parameter int MEMORY_DEPTH    = 16,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter bit FWFT            = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);
    localparam int PW = ADDRESS_SIZE + 1;

    generate
        if (MEMORY_DEPTH != (1 << ADDRESS_SIZE) ||
            ADDRESS_SIZE != addr_size_for_depth(MEMORY_DEPTH)) begin : g_bad_depth
            $error("fifo_sync_param: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
        end
        if (ALMOST_FULL_TH <= ALMOST_EMPTY_TH) begin : g_bad_th_order
            $error("fifo_sync_param: ALMOST_FULL_TH must exceed ALMOST_EMPTY_TH");
        end
        if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > MEMORY_DEPTH ||
            ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > MEMORY_DEPTH - 1) begin : g_bad_th_range
            $error("fifo_sync_param: threshold out of range");
        end
    endgenerate

    logic [PW-1:0]           w_ptr_q, w_ptr_d;
    logic [PW-1:0]           r_ptr_q, r_ptr_d;
    logic [PW-1:0]           level_q, level_d;
    fifo_flags_t             flags_q, flags_d;
    logic                    wr_ok, rd_ok;
    logic [MEMORY_WIDTH-1:0] mem_rdata;

    always_comb begin
        // Acceptance uses the registered flags, so a full FIFO refuses the write even
        // when a read in the same cycle would free a slot.
        wr_ok   = bus.w_en & ~flags_q.w_full;
        rd_ok   = bus.r_en & ~flags_q.r_empty;
        w_ptr_d = w_ptr_q + PW'(wr_ok);
        r_ptr_d = r_ptr_q + PW'(rd_ok);
        // Extra pointer bit makes the modular difference cover 0..MEMORY_DEPTH.
        level_d = w_ptr_d - r_ptr_d;

        flags_d              = flags_q;
        flags_d.w_full       = (level_d == PW'(MEMORY_DEPTH));
        flags_d.r_empty      = (level_d == '0);
        flags_d.almost_full  = (level_d >= PW'(ALMOST_FULL_TH));
        flags_d.almost_empty = (level_d <= PW'(ALMOST_EMPTY_TH));
        // A new error wins over a concurrent clear.
        flags_d.overflow     = (flags_q.overflow  & ~bus.err_clr) | (bus.w_en & flags_q.w_full);
        flags_d.underflow    = (flags_q.underflow & ~bus.err_clr) | (bus.r_en & flags_q.r_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            flags_q <= FIFO_FLAGS_RST;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            flags_q <= flags_d;
        end
    end

    fifo_sync_mem #(
        .MEMORY_WIDTH (MEMORY_WIDTH),
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .FWFT         (FWFT)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .w_en_i   (wr_ok),
        .w_addr_i (w_ptr_q[ADDRESS_SIZE-1:0]),
        .wdata_i  (bus.wdata),
        .r_en_i   (rd_ok),
        .r_addr_i (r_ptr_q[ADDRESS_SIZE-1:0]),
        .rdata_o  (mem_rdata)
    );

    // In FWFT mode the RAM output is stale or uninitialised while empty; present zero instead.
    assign bus.rdata        = (FWFT && flags_q.r_empty) ? '0 : mem_rdata;
    assign bus.level        = level_q;
    assign bus.w_full       = flags_q.w_full;
    assign bus.r_empty      = flags_q.r_empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.overflow     = flags_q.overflow;
    assign bus.underflow    = flags_q.underflow;

endmodule
